// File: rtl/led_seq_pkg.sv
// Shared types and widths for the LED sequence monitor.
// Optional error counter is enabled with LED_MON_ERR_COUNT_EN.
package led_seq_pkg;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        ACQUIRE    = 2'd1,
        TRACK_UP   = 2'd2,
        TRACK_DOWN = 2'd3
    } mon_state_e;

    localparam int BOUNCE_CNT_W = 16;
    localparam int ERR_CNT_W    = 8;

endpackage

// File: rtl/led_onehot_decode.sv
// One-hot classifier for an LED bus: flags a single lit bit
// and returns its index. Purely combinational.
module led_onehot_decode #(
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] led,
    output logic             valid,
    output logic [PW-1:0]    idx
);

    logic [WIDTH-1:0] led_m1;

    assign led_m1 = led - 1'b1;

    // Nonzero with no second bit set means exactly one bit lit.
    always_comb begin
        valid = (led != '0) && ((led & led_m1) == '0);
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (led[i]) begin
                idx = idx | PW'(i);
            end
        end
    end

endmodule

// File: rtl/led_sequence_monitor.sv
// Receive-side checker for a bouncing one-hot LED sequence.
// Define LED_MON_ERR_COUNT_EN to add the error_count output.
module led_sequence_monitor
    import led_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        led_in,
    input  logic                    led_valid,
    input  logic                    clear,
    output logic [PW-1:0]           position,
    output logic                    direction,
    output logic                    locked,
    output logic                    error,
    output logic                    fault_sticky,
    output logic [BOUNCE_CNT_W-1:0] bounce_count
`ifdef LED_MON_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0]    error_count
`endif
);

    mon_state_e state_q, state_d;

    logic [PW-1:0]           pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    lock_q, lock_d;
    logic                    err_q, err_d;
    logic                    fault_q, fault_d;
    logic [BOUNCE_CNT_W-1:0] bcnt_q, bcnt_d;

    logic          smp_ok;
    logic [PW-1:0] smp_idx;

    logic          at_top;
    logic          at_bot;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_dec;
    logic [PW-1:0] exp_idx;
    logic          exp_rev;
    logic          hit;
    logic          viol;

    led_onehot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .led   (led_in),
        .valid (smp_ok),
        .idx   (smp_idx)
    );

    assign at_top  = (pos_q == PW'(WIDTH - 1));
    assign at_bot  = (pos_q == '0);
    assign pos_inc = pos_q + 1'b1;
    assign pos_dec = pos_q - 1'b1;

    // Expected next index while tracking, folding at either end.
    always_comb begin
        exp_idx = pos_q;
        exp_rev = 1'b0;
        if (state_q == TRACK_UP) begin
            exp_idx = at_top ? pos_dec : pos_inc;
            exp_rev = at_top;
        end else if (state_q == TRACK_DOWN) begin
            exp_idx = at_bot ? pos_inc : pos_dec;
            exp_rev = at_bot;
        end
    end

    assign hit = smp_ok && (smp_idx == exp_idx);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        bcnt_d  = bcnt_q;
        viol    = 1'b0;
        if (led_valid) begin
            unique case (state_q)
                SYNC: begin
                    if (smp_ok) begin
                        pos_d   = smp_idx;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (!smp_ok) begin
                        state_d = SYNC;
                    end else begin
                        pos_d = smp_idx;
                        if (!at_top && smp_idx == pos_inc) begin
                            state_d = TRACK_UP;
                        end else if (!at_bot && smp_idx == pos_dec) begin
                            state_d = TRACK_DOWN;
                        end
                    end
                end
                TRACK_UP, TRACK_DOWN: begin
                    if (hit) begin
                        pos_d = smp_idx;
                        if (exp_rev) begin
                            state_d = (state_q == TRACK_UP) ?
                                      TRACK_DOWN : TRACK_UP;
                            if (bcnt_q != '1) begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                    end else begin
                        viol    = 1'b1;
                        state_d = SYNC;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // Registered status; a violation outranks a same-cycle clear.
    always_comb begin
        lock_d  = (state_d == TRACK_UP) || (state_d == TRACK_DOWN);
        dir_d   = (state_d == TRACK_DOWN);
        err_d   = viol;
        fault_d = fault_q;
        if (viol) begin
            fault_d = 1'b1;
        end else if (clear) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SYNC;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign position     = pos_q;
    assign direction    = dir_q;
    assign locked       = lock_q;
    assign error        = err_q;
    assign fault_sticky = fault_q;
    assign bounce_count = bcnt_q;

`ifdef LED_MON_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (viol && ecnt_q != '1) begin
            ecnt_d = ecnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign error_count = ecnt_q;
`endif

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Randomized bench for led_sequence_monitor against a behavioural model.
// Honours LED_MON_ERR_COUNT_EN when the design is built with it.
module tb_led_sequence_monitor;

    localparam int W  = 8;
    localparam int PW = $clog2(W);

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  led_in;
    logic          led_valid;
    logic          clear;
    logic [PW-1:0] position;
    logic          direction;
    logic          locked;
    logic          error;
    logic          fault_sticky;
    logic [15:0]   bounce_count;
`ifdef LED_MON_ERR_COUNT_EN
    logic [7:0]    error_count;
`endif

    led_sequence_monitor #(
        .WIDTH (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .led_in       (led_in),
        .led_valid    (led_valid),
        .clear        (clear),
        .position     (position),
        .direction    (direction),
        .locked       (locked),
        .error        (error),
        .fault_sticky (fault_sticky),
        .bounce_count (bounce_count)
`ifdef LED_MON_ERR_COUNT_EN
        ,
        .error_count  (error_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Model: an anchor point, then a walking bit with a +1/-1 stride.
    int m_pos, m_dir, m_bc, m_ec;
    bit m_anch, m_trk, m_err, m_fs;

    task automatic model(input bit v, input logic [W-1:0] d,
                         input bit clr, input bit rst);
        int  idx, nxt, ndir;
        bit  ok, bad;
        if (rst) begin
            m_pos = 0; m_dir = 1; m_bc = 0; m_ec = 0;
            m_anch = 0; m_trk = 0; m_err = 0; m_fs = 0;
            return;
        end
        bad = 0;
        if (v) begin
            ok  = ($countones(d) == 1);
            idx = 0;
            for (int i = 0; i < W; i++) if (d[i]) idx = i;
            if (m_trk) begin
                ndir = m_dir;
                nxt  = m_pos + ndir;
                if (nxt < 0 || nxt > W - 1) begin
                    ndir = -ndir;
                    nxt  = m_pos + ndir;
                end
                if (ok && idx == nxt) begin
                    if (ndir != m_dir && m_bc < 65535) m_bc++;
                    m_dir = ndir;
                    m_pos = idx;
                end else begin
                    bad = 1; m_trk = 0; m_anch = 0;
                end
            end else if (m_anch) begin
                if (!ok) m_anch = 0;
                else begin
                    if (idx - m_pos == 1 || m_pos - idx == 1) begin
                        m_trk = 1;
                        m_dir = idx - m_pos;
                    end
                    m_pos = idx;
                end
            end else if (ok) begin
                m_anch = 1;
                m_pos  = idx;
            end
        end
        m_err = bad;
        if (bad) begin
            m_fs = 1;
            if (m_ec < 255) m_ec++;
        end else if (clr) m_fs = 0;
    endtask

    task automatic check_all();
        check("position", 32'(position), 32'(m_pos));
        check("direction", 32'(direction), 32'(m_trk && m_dir < 0));
        check("locked", 32'(locked), 32'(m_trk));
        check("error", 32'(error), 32'(m_err));
        check("fault_sticky", 32'(fault_sticky), 32'(m_fs));
        check("bounce_count", 32'(bounce_count), 32'(m_bc));
`ifdef LED_MON_ERR_COUNT_EN
        check("error_count", 32'(error_count), 32'(m_ec));
`endif
    endtask

    task automatic step(input bit v, input logic [W-1:0] d,
                        input bit clr, input bit rst);
        led_valid = v; led_in = d; clear = clr; reset = rst;
        @(posedge clock);
        model(v, d, clr, rst);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic feed_pos(input int p);
        feed(W'(1) << p);
    endtask

    int g_pos, g_dir, r;
    bit rv, rc, rr;
    logic [W-1:0] rd;

    initial begin
        led_valid = 0; led_in = '0; clear = 0; reset = 1;
        step(1'b0, '0, 1'b0, 1'b1);
        check("rst_position", 32'(position), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_bounce", 32'(bounce_count), 32'd0);

        // Full bounce 0..7..0..1
        for (int p = 0; p < W; p++) begin
            feed_pos(p);
            if (p == 1) check("lock_after_02", 32'(locked), 32'd1);
        end
        for (int p = W - 2; p >= 0; p--) begin
            feed_pos(p);
            check("dir_down", 32'(direction), 32'd1);
        end
        feed_pos(1);
        check("dir_up_again", 32'(direction), 32'd0);
        check("bounce_two", 32'(bounce_count), 32'd2);
        check("no_fault", 32'(fault_sticky), 32'd0);

        // Multi-hot while tracking up at 08
        step(1'b0, '0, 1'b0, 1'b1);
        feed(8'h04); feed(8'h08); feed(8'h18);
        check("mh_error", 32'(error), 32'd1);
        check("mh_fault", 32'(fault_sticky), 32'd1);
        check("mh_locked", 32'(locked), 32'd0);
        check("mh_pos", 32'(position), 32'd3);
        step(1'b0, '0, 1'b0, 1'b0);
        check("mh_pulse_end", 32'(error), 32'd0);

        // Skip while tracking, then re-lock
        feed(8'h04); feed(8'h08); feed(8'h20);
        check("skip_error", 32'(error), 32'd1);
        check("skip_pos", 32'(position), 32'd3);
        feed(8'h40); feed(8'h80);
        check("relock", 32'(locked), 32'd1);
        check("relock_dir", 32'(direction), 32'd0);

        // Idle with garbage on the bus
        feed(8'h40);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, W'($urandom), 1'b0, 1'b0);
            check("idle_pos", 32'(position), 32'd6);
            check("idle_err", 32'(error), 32'd0);
        end
        feed(8'h20);

        // Reset with three bounces on the clock
        step(1'b0, '0, 1'b0, 1'b1);
        for (int p = 0; p < W; p++) feed_pos(p);
        for (int p = W - 2; p >= 0; p--) feed_pos(p);
        for (int p = 1; p < W; p++) feed_pos(p);
        feed_pos(W - 2);
        check("three_bounces", 32'(bounce_count), 32'd3);
        step(1'b1, 8'h10, 1'b0, 1'b1);
        check("mid_rst_bc", 32'(bounce_count), 32'd0);
        check("mid_rst_lock", 32'(locked), 32'd0);
        check("mid_rst_pos", 32'(position), 32'd0);
        feed(8'h10); feed(8'h08);
        check("rst_relock", 32'(locked), 32'd1);
        check("rst_relock_dir", 32'(direction), 32'd1);

        // Clear racing a violation, then clear alone
        feed(8'hFF);
        feed(8'h04); feed(8'h08);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        check("clr_vs_err", 32'(fault_sticky), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("clr_alone", 32'(fault_sticky), 32'd0);

        // Random traffic from a legal sequencer with injected faults
        g_pos = 0; g_dir = 1;
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(99);
            rv = ($urandom_range(9) != 0);
            rc = ($urandom_range(19) == 0);
            rr = ($urandom_range(199) == 0);
            if (r < 88) rd = W'(1) << g_pos;
            else rd = W'($urandom);
            if (rv && r < 88) begin
                if (g_pos + g_dir < 0 || g_pos + g_dir > W - 1)
                    g_dir = -g_dir;
                g_pos = g_pos + g_dir;
            end
            step(rv, rd, rc, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_sequence_monitor.md
# led_sequence_monitor

Receive-side checker for the bouncing one-hot LED sequence driven by the LED sequencer. Samples the LED bus on a valid strobe, locks onto the walking bit, and reports its position and direction. Counts end-of-travel reversals and flags any step that breaks the bounce protocol. Sits beside the sequencer output, in the self-test path of the board bring-up design.

## Interface
- WIDTH, 8, LED bus width; legal range is 2 or more.
- PW, $clog2(WIDTH), position width; localparam, not overridable.
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- led_in  in  WIDTH  LED bus under test; bit 0 is position 0.
- led_valid  in  1  led_in holds a new sample this cycle.
- clear  in  1  clears fault_sticky.
- position  out  PW  index of the lit bit in the last accepted sample.
- direction  out  1  0 = moving up (left shift), 1 = moving down.
- locked  out  1  monitor is tracking a valid sequence.
- error  out  1  one-cycle pulse on a protocol violation.
- fault_sticky  out  1  set by error; cleared by clear or reset.
- bounce_count  out  16  number of reversals taken; saturates at 16'hFFFF.

## Operation
- A sample is taken only in cycles where led_valid=1. All state and outputs hold when led_valid=0.
- Sample classification (combinational): valid when exactly one bit is set, giving index idx. Zero or multi-hot samples are invalid.
- FSM states: SYNC, ACQUIRE, TRACK_UP, TRACK_DOWN.
- Expected next index in TRACK_UP: position+1. At position WIDTH-1 the expected index is WIDTH-2, which is a reversal.
- Expected next index in TRACK_DOWN: position-1. At position 0 the expected index is 1, which is a reversal.
- SYNC:
  - Valid sample: position<=idx, go to ACQUIRE.
  - Invalid sample: stay in SYNC.
  - No error is raised in this state.
- ACQUIRE:
  - Valid sample with idx = position+1: go to TRACK_UP.
  - Valid sample with idx = position-1: go to TRACK_DOWN.
  - Any other valid idx: position<=idx, stay in ACQUIRE.
  - Invalid sample: go to SYNC.
  - No error is raised in this state.
- TRACK_UP / TRACK_DOWN:
  - Sample equal to the expected index: position<=idx. On a reversal, switch state and increment bounce_count.
  - Any other sample, valid or invalid: error=1 for one cycle, fault_sticky<=1, go to SYNC. position and direction hold.
- locked=1 exactly in TRACK_UP and TRACK_DOWN. direction=1 exactly in TRACK_DOWN; otherwise 0.
- Simultaneous clear and error: error wins, so fault_sticky stays 1.
- Reset mid-operation: at the next edge, state is SYNC and every output is 0.
- Reset values: position=0, direction=0, locked=0, error=0, fault_sticky=0, bounce_count=0, error_count=0.

## Timing
- All outputs are registered. A sample accepted at edge N is reflected in the outputs after edge N.
- locked rises after the second consecutive adjacent valid sample, at the earliest two samples after reset.
- error is high for exactly the one cycle following the offending sample edge.
- Back-to-back samples are supported: led_valid may be high every cycle, with no throughput limit.

## Configuration
- LED_MON_ERR_COUNT_EN defined:
  - Adds output error_count  out  8.
  - error_count increments on each error pulse and saturates at 8'hFF.
  - Reset clears it; clear does not.
- LED_MON_ERR_COUNT_EN undefined: no error_count port and no counter logic. All other behaviour is identical.

## Structure
- Package led_seq_pkg holds:
  - the state enum (SYNC, ACQUIRE, TRACK_UP, TRACK_DOWN);
  - the bounce_count width constant (16);
  - the error_count width constant (8).
- Sub-module led_onehot_decode: purely combinational, WIDTH-parameterised. Outputs a valid flag and the PW-bit idx. It is reusable by other LED-bus consumers.
- Top level: FSM, position/direction registers, counters.

## Test plan
- WIDTH=8, led_valid=1 every cycle, feed 01,02,…,80,40,…,01,02:
  - locked=1 after the 02 sample.
  - position follows 0..7..0..1; direction=1 from the 40 sample through the 01 sample.
  - bounce_count=2 at the end; error never asserted.
- Locked and going up at 08, then feed 18 (multi-hot):
  - error pulses one cycle, fault_sticky=1, locked=0, position stays 3.
  - error_count=1 when the macro is defined.
- Locked up at 08, then feed 20 (skip): same error response. Then feed 40 followed by 80: locked=1 again, direction=0.
- Toggle led_valid to 0 for 5 cycles mid-sequence with garbage on led_in: no output changes and no error.
- Assert reset for one cycle while tracking with bounce_count=3: all outputs read 0 the next cycle, and re-lock occurs after two adjacent samples.
- Fault present; drive clear on the same cycle as a new violating sample: fault_sticky stays 1. Clear alone on a later cycle: fault_sticky=0.
